shift_unit_32: RTL and testbench

SHIFT_UNIT_32 -- requirements
Module: shift_unit_32

---
 rtl/shift_unit_32.sv | 113 +++++++++++
 tb/tb_shift_unit_32.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/shift_unit_32.sv
// shift_unit_32: multi-cycle 32-bit shifter/rotator. One bit position is
// moved per clock while a down-counter loaded with the shift amount runs
// to zero; the result is then registered on data_out with a one-cycle
// done pulse.
//
// Handshake: start is a request sampled only while idle (busy low). A
// request is accepted on the rising edge where start=1 and the block is
// idle; data_in, op and shamt are captured on that same edge and ignored
// afterwards. busy stays high from the accepting edge until the edge that
// leaves DONE. done pulses for exactly one cycle with data_out already
// valid. Requests made while busy are dropped, never queued.
module shift_unit_32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] data_in,
  input  logic [4:0]  shamt,
  output logic [31:0] data_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
  localparam logic [2:0] OP_ROL = 3'b101;

  state_t      state;
  state_t      state_next;
  logic [31:0] work_reg;
  logic [31:0] work_step;
  logic [4:0]  cnt;
  logic [2:0]  op_reg;

  // State register; reset forces IDLE and overrides any request.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode: accept in IDLE, count in SHIFT, one cycle in DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == 5'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Single-bit move of the working register for the captured operation;
  // unknown op codes leave the value untouched.
  always_comb begin
    work_step = work_reg;
    case (op_reg)
      OP_SLL:  work_step = {work_reg[30:0], 1'b0};
      OP_SRL:  work_step = {1'b0, work_reg[31:1]};
      OP_SRA:  work_step = {work_reg[31], work_reg[31:1]};
      OP_ROR:  work_step = {work_reg[0], work_reg[31:1]};
      OP_ROL:  work_step = {work_reg[30:0], work_reg[31]};
      default: work_step = work_reg;
    endcase
  end

  // Datapath: capture on accept, step while counting, publish on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      work_reg <= 32'h0;
      cnt      <= 5'd0;
      op_reg   <= 3'b000;
      data_out <= 32'h0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work_reg <= data_in;
            cnt      <= shamt;
            op_reg   <= op;
          end
        end
        SHIFT: begin
          if (cnt != 5'd0) begin
            work_reg <= work_step;
            cnt      <= cnt - 5'd1;
          end else begin
            data_out <= work_reg;
            done     <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

  // Busy covers the whole operation including the completion cycle.
  assign busy = (state == SHIFT) || (state == DONE);

endmodule

// File: tb/tb_shift_unit_32.sv
// Bench for shift_unit_32: directed cases, a reset abort, and randomized
// operations checked against an arithmetic reference of each operation.
module tb_shift_unit_32;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [31:0] data_out;
  logic        busy;
  logic        done;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] prev_out;

  shift_unit_32 dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .data_in  (data_in),
    .shamt    (shamt),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: whole-amount shifts and rotates computed in one step.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] d,
                                            input int s);
    logic [31:0] r;
    case (o)
      3'b001:  r = d << s;
      3'b010:  r = d >> s;
      3'b011:  r = 32'($signed(d) >>> s);
      3'b100:  r = (s == 0) ? d : ((d >> s) | (d << (32 - s)));
      3'b101:  r = (s == 0) ? d : ((d << s) | (d >> (32 - s)));
      default: r = d;
    endcase
    return r;
  endfunction

  // Issue one operation and follow it to completion. Inputs are scrambled
  // after the accepting edge, start is toggled while busy, and start is
  // raised in the DONE cycle to confirm it is dropped.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] d,
                       input logic [4:0] s, input logic [31:0] exp);
    int k;
    int busy_cycles;
    bit seen;
    @(negedge clk);
    start = 1'b1; op = o; data_in = d; shamt = s;
    @(posedge clk); // E0
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom); data_in = $urandom; shamt = 5'($urandom);
    chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
    busy_cycles = 1;
    seen = 1'b0;
    for (k = 1; k <= int'(s) + 4; k++) begin
      start = 1'($urandom_range(0, 1));
      data_in = $urandom;
      @(posedge clk);
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (data_out !== prev_out) chk({tag, "_hold"}, data_out, prev_out);
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (!seen) begin
      start = 1'b0;
      return;
    end
    chk({tag, "_latency"}, 32'(k), 32'(int'(s) + 1));
    chk({tag, "_data"}, data_out, exp);
    prev_out = exp;
    start = 1'b1; // lost: block is in DONE
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(int'(s) + 2));
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    chk({tag, "_done_width"}, 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_no_second"}, {30'd0, busy, done}, 32'd0);
    chk({tag, "_data_held"}, data_out, exp);
  endtask

  initial begin
    int seen_done;
    reset = 1'b1; start = 1'b0; op = 3'b000; data_in = 32'h0; shamt = 5'd0;
    prev_out = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_data", data_out, 32'h0);
    chk("reset_flags", {30'd0, busy, done}, 32'd0);
    reset = 1'b0;

    // Idle with start low holds everything.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_hold", {data_out[29:0], busy, done}, 32'd0);

    // Directed cases.
    do_op("sll_1_4",   3'b001, 32'h00000001, 5'd4,  32'h00000010);
    do_op("sra_31",    3'b011, 32'h80000000, 5'd31, 32'hFFFFFFFF);
    do_op("srl_31",    3'b010, 32'h80000000, 5'd31, 32'h00000001);
    do_op("ror_1",     3'b100, 32'h00000001, 5'd1,  32'h80000000);
    do_op("rol_4",     3'b101, 32'h80000001, 5'd4,  32'h00000018);
    do_op("pass_111",  3'b111, 32'hDEADBEEF, 5'd3,  32'hDEADBEEF);
    do_op("pass_000",  3'b000, 32'hCAFEF00D, 5'd2,  32'hCAFEF00D);
    do_op("sll_zero",  3'b001, 32'h12345678, 5'd0,  32'h12345678);

    // Reset during an operation aborts it with no done and clears data_out.
    @(negedge clk);
    start = 1'b1; op = 3'b001; data_in = 32'hFFFFFFFF; shamt = 5'd20;
    @(posedge clk); // E0
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk); // E1..E9
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); // E10
    @(negedge clk);
    reset = 1'b0;
    chk("abort_data", data_out, 32'h0);
    chk("abort_flags", {30'd0, busy, done}, 32'd0);
    seen_done = 0;
    repeat (25) begin
      @(posedge clk);
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    chk("abort_quiet", 32'(seen_done), 32'd0);
    chk("abort_data_kept", data_out, 32'h0);
    prev_out = 32'h0;

    // First operation after reset, inputs changed mid-flight inside do_op.
    do_op("post_reset", 3'b101, 32'h0F0F0001, 5'd8, 32'h0F00010F);

    // Randomized operations against the reference.
    for (int i = 0; i < 24; i++) begin
      logic [2:0]  ro;
      logic [31:0] rd;
      logic [4:0]  rs;
      ro = 3'($urandom_range(0, 7));
      rd = $urandom;
      rs = 5'($urandom_range(0, 31));
      do_op($sformatf("rand%0d_op%0d_s%0d", i, ro, rs), ro, rd, rs, ref_model(ro, rd, int'(rs)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
